// File: rtl/clock_edge_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clock_edge_monitor: slow-clock synchronizer, edge strobes, half-period      |
// | measurement with lock / out-of-range / lost status.   Rev 1.0               |
// +----------------------------------------------------------------------------+
module clock_edge_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int MIN_HALF    = 58,
   parameter int MAX_HALF    = 62,
   parameter int TIMEOUT     = 200,
   parameter int LOCK_COUNT  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             slowClock,
   output logic             risePulse,
   output logic             fallPulse,
   output logic [CNT_W-1:0] halfPeriod,
   output logic             periodValid,
   output logic             outOfRange,
   output logic             lost,
   output logic             locked
);

   localparam int c_GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]    c_TIMEOUT    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]    c_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]    c_MIN_HALF   = CNT_W'(MIN_HALF);
   localparam logic [CNT_W-1:0]    c_MAX_HALF   = CNT_W'(MAX_HALF);
   localparam logic [c_GOOD_W-1:0] c_LOCK       = c_GOOD_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_FIRST   = 2'd1,
      ST_TRACK   = 2'd2
   } state_t;

   state_t                r_state, w_stateNext;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                  r_prev, r_edge, r_lvl;
   logic [CNT_W-1:0]      r_cnt, w_cntNext;
   logic [c_GOOD_W-1:0]   r_good, w_goodNext;
   logic [CNT_W-1:0]      r_hp, w_hpNext;
   logic                  r_pv, w_pvNext;
   logic                  r_rise, w_riseNext;
   logic                  r_fall, w_fallNext;
   logic                  r_oor, w_oorNext;
   logic                  r_lost, w_lostNext;
   logic                  r_locked, w_lockedNext;
   logic                  r_pend, w_pendNext;
   logic                  w_syncOut, w_accept, w_inRange;
   logic [CNT_W-1:0]      w_meas;

   assign w_syncOut = r_sync[SYNC_STAGES-1];
   assign w_accept  = enable & r_edge;
   assign w_meas    = r_cnt + 1'b1;
   assign w_inRange = (w_meas >= c_MIN_HALF) && (w_meas <= c_MAX_HALF);

   // Edge history runs free of enable so re-enabling never produces a stale edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_edge <= 1'b0;
         r_lvl  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], slowClock};
         r_prev <= w_syncOut;
         r_edge <= w_syncOut ^ r_prev;
         r_lvl  <= w_syncOut;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_ACQUIRE;
      else       r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_goodNext  = r_good;
      w_hpNext    = r_hp;
      w_pvNext    = 1'b0;
      w_riseNext  = 1'b0;
      w_fallNext  = 1'b0;
      w_oorNext   = r_oor;
      w_lostNext  = r_lost;
      w_pendNext  = r_pend;
      if (enable) begin
         w_pendNext = 1'b0;
         if (w_accept) begin
            w_riseNext = r_lvl;
            w_fallNext = ~r_lvl;
            w_cntNext  = '0;
            w_lostNext = 1'b0;
            if (r_state == ST_ACQUIRE) begin
               w_stateNext = ST_FIRST;
            end else begin
               w_stateNext = ST_TRACK;
               w_hpNext    = w_meas;
               w_pvNext    = 1'b1;
               if (w_inRange) begin
                  w_goodNext = (r_good == c_LOCK) ? r_good : r_good + 1'b1;
                  w_oorNext  = 1'b0;
               end else begin
                  w_goodNext = '0;
                  w_oorNext  = 1'b1;
               end
            end
         end else begin
            if (r_pend) w_lostNext = 1'b1;
            if (r_cnt != c_TIMEOUT) w_cntNext = r_cnt + 1'b1;
            // Timeout: leave tracking now, raise lost on the following cycle.
            if ((r_state != ST_ACQUIRE) && (r_cnt == c_TIMEOUT_M1)) begin
               w_stateNext = ST_ACQUIRE;
               w_goodNext  = '0;
               w_pendNext  = 1'b1;
            end
         end
      end
      w_lockedNext = (w_goodNext == c_LOCK) && (w_stateNext == ST_TRACK);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt    <= '0;
         r_good   <= '0;
         r_hp     <= '0;
         r_pv     <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_oor    <= 1'b0;
         r_lost   <= 1'b0;
         r_locked <= 1'b0;
         r_pend   <= 1'b0;
      end else begin
         r_cnt    <= w_cntNext;
         r_good   <= w_goodNext;
         r_hp     <= w_hpNext;
         r_pv     <= w_pvNext;
         r_rise   <= w_riseNext;
         r_fall   <= w_fallNext;
         r_oor    <= w_oorNext;
         r_lost   <= w_lostNext;
         r_locked <= w_lockedNext;
         r_pend   <= w_pendNext;
      end
   end

   assign risePulse   = r_rise;
   assign fallPulse   = r_fall;
   assign halfPeriod  = r_hp;
   assign periodValid = r_pv;
   assign outOfRange  = r_oor;
   assign lost        = r_lost;
   assign locked      = r_locked;

endmodule
`default_nettype wire

// File: doc/clock_edge_monitor.md
# clock_edge_monitor

Receive-side companion to the system clock divider. It takes a slow clock (nominally 200 kHz, generated from the 24 MHz system clock) back into the fast domain. It synchronizes the slow clock and emits single-cycle rising and falling edge strobes. It measures every half-period in fast-clock cycles and reports lock, out-of-range and lost-clock status. Downstream serial logic uses the strobes instead of clocking on the slow clock directly.

## Interface
- SYNC_STAGES, 2: synchronizer flops on slowClock (at least 2).
- CNT_W, 8: width of the half-period counter and of halfPeriod.
- MIN_HALF, 58: smallest in-range half-period, in cycles.
- MAX_HALF, 62: largest in-range half-period, in cycles.
- TIMEOUT, 200: counter value with no edge that declares the clock lost. Must satisfy MAX_HALF < TIMEOUT ≤ 2^CNT_W−1.
- LOCK_COUNT, 4: consecutive in-range half-periods required for lock.

Ports:
- clock  in  1  system clock (24 MHz).
- reset  in  1  synchronous, active-high.
- enable  in  1  qualifies all state updates.
- slowClock  in  1  asynchronous slow clock.
- risePulse  out  1  one-cycle strobe per detected rising edge.
- fallPulse  out  1  one-cycle strobe per detected falling edge.
- halfPeriod  out  CNT_W  most recent measured half-period.
- periodValid  out  1  one-cycle strobe when halfPeriod updates.
- outOfRange  out  1  sticky flag: last measurement was outside [MIN_HALF, MAX_HALF].
- lost  out  1  level: no edge seen for TIMEOUT cycles.
- locked  out  1  level: tracking a clock that is in range.

## Operation
Synchronizer and edge detection:
- The synchronizer chain and the edge-detect history register (`prev`) shift every cycle regardless of enable.
- edge = syncOut XOR prev.
- An edge is "accepted" only when enable=1.

Half-period counter `cnt`:
- Increments while enable=1 and no edge is accepted.
- Saturates at TIMEOUT.
- Clears to 0 on an accepted edge.

FSM states and transitions:
- ACQUIRE:
  - Entered on reset and on timeout.
  - First accepted edge → FIRST.
  - No measurement is produced, because there is no prior reference edge.
- FIRST: next accepted edge gives the first measurement → TRACK.
- TRACK:
  - Every accepted edge produces a measurement.
  - cnt reaching TIMEOUT → ACQUIRE.
- Timeout also applies in FIRST → ACQUIRE.

Measurement (in FIRST and TRACK, on an accepted edge):
- halfPeriod = cnt+1, truncated to CNT_W; saturation guarantees no wrap.
- periodValid = 1 for one cycle.
- In range (MIN_HALF ≤ value ≤ MAX_HALF):
  - goodCnt increments, saturating at LOCK_COUNT.
  - outOfRange clears.
- Out of range:
  - goodCnt = 0, outOfRange = 1, locked = 0.

Status outputs:
- locked = 1 when goodCnt == LOCK_COUNT and state is TRACK.
- lost:
  - Set on the TIMEOUT transition.
  - Also clears goodCnt and locked.
  - Cleared by the next accepted edge.

enable=0:
- cnt, FSM, goodCnt and all status outputs hold.
- Strobes are forced to 0.
- Because `prev` keeps tracking, no spurious edge appears when enable re-asserts.

Reset values: all outputs 0, halfPeriod = 0, state ACQUIRE, cnt = 0, goodCnt = 0, sync chain and prev = 0.

## Timing
- All outputs are registered.
- Strobe latency:
  - slowClock is first sampled at a new level on edge N.
  - risePulse/fallPulse are high for exactly one cycle, after edge N+SYNC_STAGES+1.
- halfPeriod and periodValid change on the same edge as the corresponding strobe.
- Period check: a 200 kHz input at 50% duty measures 60 on every edge, ±1 from sampling jitter.
- Minimum resolvable half-period: 1 cycle. Consecutive strobes alternate rise/fall.
- Timeout fires on the edge where cnt would pass TIMEOUT−1. lost rises one cycle later.
- Edge and timeout in the same cycle: the edge wins. It is measured as TIMEOUT, which is out of range, and lost is not set.
- Reset has priority over enable and over any edge. A reset during TRACK returns to ACQUIRE next cycle.

## Test plan
- Reset with slowClock toggling:
  - All outputs 0 during reset.
  - The first accepted edge after release gives no periodValid.
- Ideal 200 kHz input (60/60):
  - risePulse and fallPulse are one cycle each, SYNC_STAGES+1 cycles after the transition.
  - halfPeriod = 60 from the second edge onward.
  - locked = 1 after the 4th in-range measurement.
- Locked, then one half-period of 40:
  - halfPeriod = 40, outOfRange = 1, locked = 0.
  - Four further 60-cycle halves restore locked = 1 and outOfRange = 0.
- Locked, then slowClock held high:
  - lost = 1 and locked = 0 at 201 cycles after the last edge.
  - The next edge clears lost and gives no measurement.
- enable=0 for 30 cycles spanning an edge:
  - No strobes; cnt frozen.
  - The next measurement excludes the frozen cycles.
  - No edge is emitted at re-enable.
- Reset asserted mid-TRACK:
  - Next cycle: state ACQUIRE, locked = 0, halfPeriod = 0.
  - Reacquires normally afterwards.
